trig_counter_bank: RTL and testbench
====================================

# trig_counter_bank

Parametrised bank of NCH independent WIDTH-bit counters driven by one-cycle trigger pulses from the host trigger-in endpoints. It adds load, per-channel free-run, wrap or saturate mode, sticky overflow flags, and an atomic snapshot of all channels. The snapshot lets the host read wide counters through several 16-bit wire-outs without tearing. The block sits between the trigger-in/wire-in endpoints and the wire-out endpoints, in the sys_clk domain.

## Interface
Parameters:
- NCH, 4, number of counter channels (1..16)
- WIDTH, 32, counter width in bits (2..64)

Ports:
- sys_clk  in  1  clock; reset synchronous, active-high; clock sys_clk
- reset  in  1  synchronous active-high; clears all state
- trig_reset  in  NCH  per-channel pulse: counter to 0 and clear flag
- trig_load  in  NCH  per-channel pulse: counter to load_value
- trig_up  in  NCH  per-channel pulse: +1
- trig_down  in  NCH  per-channel pulse: -1
- load_value  in  WIDTH  shared load operand
- free_run  in  NCH  level; channel counts up every cycle when no trigger is active
- sat_mode  in  NCH  level; 1 = saturate at 0 and at all-ones, 0 = wrap
- flag_clear  in  NCH  per-channel pulse: clear ovf_flag
- snap_req  in  1  pulse: capture all counters
- count  out  NCH*WIDTH  live counters; channel i at [i*WIDTH +: WIDTH]
- snap_data  out  NCH*WIDTH  captured counters, same packing
- snap_valid  out  1  one-cycle pulse when snap_data updates
- ovf_flag  out  NCH  sticky wrap or saturation indicator

## Operation
- Each channel selects exactly one operation per cycle. Priority: reset > load > up/down > free_run > hold.
- trig_up and trig_down together, with no reset or load: net zero, hold, no flag. free_run is ignored that cycle.
- free_run with no trigger: increment by 1.
- Increment from all-ones:
  - wrap mode: result 0, ovf_flag set.
  - saturate mode: result stays all-ones, ovf_flag set.
- Decrement from 0:
  - wrap mode: result all-ones, ovf_flag set.
  - saturate mode: result stays 0, ovf_flag set.
- ovf_flag is sticky. It clears on trig_reset, flag_clear or global reset.
  - Clear and a new overflow in the same cycle: set wins.
  - A load never sets the flag.
- sat_mode changes take effect on the next operation; the counter value is never altered.
- snap_req captures the registered count of all channels simultaneously, i.e. the values before any update in the same cycle.
- snap_req pulses on consecutive cycles each produce a capture and a snap_valid.

## Timing
- All outputs are registered. Reset values: count = 0, snap_data = 0, snap_valid = 0, ovf_flag = 0.
- Trigger at edge N: count and ovf_flag reflect the result after edge N, 1-cycle latency.
- snap_req sampled at edge N: snap_data holds count as it was before edge N, and snap_valid is high for the cycle after edge N.
- reset asserted at any time, including with triggers or snap_req active: all triggers are ignored and outputs go to reset values at the next edge.
- Triggers are assumed to be single-cycle pulses. A held trigger acts once per cycle.

## Structure
- Package trig_counter_pkg holds:
  - typedef enum cnt_op_t {OP_HOLD, OP_RST, OP_LOAD, OP_INC, OP_DEC}
  - constants NCH_MAX = 16 and WIDTH_MAX = 64.
- Sub-module counter_channel is one counter: priority decode, wrap/saturate arithmetic, sticky flag. The top level instantiates it NCH times through generate.
- The top level owns the snapshot register, snap_valid and output packing.

## Test plan
- Reset, then pulse trig_up[0] ×3 and trig_down[0] ×1: count[0] = 2; other channels stay 0.
- WIDTH=8, sat_mode[1]=0, load 0xFF, one trig_up: count = 0x00, ovf_flag[1] = 1; flag_clear pulse gives flag 0.
- WIDTH=8, sat_mode[2]=1, load 0x01, trig_down ×3: count stays 0x00, flag set on the second down; trig_reset clears the flag.
- Same cycle trig_reset, trig_load (0x55) and trig_up: count = 0. Then trig_up and trig_down together: count holds 0, flag stays 0.
- free_run[3]=1 for 10 cycles from 0, with trig_load 0x100 at cycle 5: final value is 0x104, and each cycle's value is checked.
- snap_req in the same cycle as trig_up on channel 0 (count was 7): snap_data[0] = 7, count[0] = 8, snap_valid high for exactly 1 cycle. Assert reset mid-run: snap_valid = 0 and everything is 0 on the next cycle.

Source files
------------

// File: rtl/trig_counter_pkg.sv
// Shared types and limits for the trigger-driven counter bank.
package trig_counter_pkg;

  localparam int NCH_MAX   = 16;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_RST,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } cnt_op_t;

endpackage

// File: rtl/counter_channel.sv
// One counter channel: trigger priority decode, wrap/saturate arithmetic and
// a sticky overflow flag.
module counter_channel
  import trig_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             trig_reset,
  input  logic             trig_load,
  input  logic             trig_up,
  input  logic             trig_down,
  input  logic [WIDTH-1:0] load_value,
  input  logic             free_run,
  input  logic             sat_mode,
  input  logic             flag_clear,
  output logic [WIDTH-1:0] count,
  output logic             ovf_flag
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  cnt_op_t          op;
  logic             ovf_event;
  logic [WIDTH-1:0] count_d, count_q;
  logic             flag_d, flag_q;

  // Simultaneous up and down cancel out and also suppress free-run.
  always_comb begin
    op = OP_HOLD;
    if (trig_reset) begin
      op = OP_RST;
    end else if (trig_load) begin
      op = OP_LOAD;
    end else if (trig_up && trig_down) begin
      op = OP_HOLD;
    end else if (trig_up) begin
      op = OP_INC;
    end else if (trig_down) begin
      op = OP_DEC;
    end else if (free_run) begin
      op = OP_INC;
    end
  end

  always_comb begin
    count_d   = count_q;
    ovf_event = 1'b0;
    case (op)
      OP_RST:  count_d = '0;
      OP_LOAD: count_d = load_value;
      OP_INC: begin
        if (count_q == ALL_ONES) begin
          ovf_event = 1'b1;
          count_d   = sat_mode ? ALL_ONES : '0;
        end else begin
          count_d = count_q + ONE;
        end
      end
      OP_DEC: begin
        if (count_q == '0) begin
          ovf_event = 1'b1;
          count_d   = sat_mode ? '0 : ALL_ONES;
        end else begin
          count_d = count_q - ONE;
        end
      end
      default: count_d = count_q;
    endcase

    // A fresh overflow outranks a flag_clear arriving in the same cycle.
    flag_d = flag_q;
    if (op == OP_RST) begin
      flag_d = 1'b0;
    end else if (ovf_event) begin
      flag_d = 1'b1;
    end else if (flag_clear) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count    = count_q;
  assign ovf_flag = flag_q;

endmodule

// File: rtl/trig_counter_bank.sv
// Bank of NCH trigger-driven counters with an atomic snapshot so the host can
// read wide counters over narrow wire-outs without tearing.
module trig_counter_bank
  import trig_counter_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 32
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       trig_reset,
  input  logic [NCH-1:0]       trig_load,
  input  logic [NCH-1:0]       trig_up,
  input  logic [NCH-1:0]       trig_down,
  input  logic [WIDTH-1:0]     load_value,
  input  logic [NCH-1:0]       free_run,
  input  logic [NCH-1:0]       sat_mode,
  input  logic [NCH-1:0]       flag_clear,
  input  logic                 snap_req,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH*WIDTH-1:0] snap_data,
  output logic                 snap_valid,
  output logic [NCH-1:0]       ovf_flag
);

  logic [NCH*WIDTH-1:0] snap_data_d, snap_data_q;
  logic                 snap_valid_d, snap_valid_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    counter_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .trig_reset(trig_reset[i]),
      .trig_load (trig_load[i]),
      .trig_up   (trig_up[i]),
      .trig_down (trig_down[i]),
      .load_value(load_value),
      .free_run  (free_run[i]),
      .sat_mode  (sat_mode[i]),
      .flag_clear(flag_clear[i]),
      .count     (count[i*WIDTH +: WIDTH]),
      .ovf_flag  (ovf_flag[i])
    );
  end

  // count is already registered, so capturing it yields pre-update values.
  always_comb begin
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_req;
    if (snap_req) begin
      snap_data_d = count;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign snap_data  = snap_data_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_trig_counter_bank.sv
// Directed, table-driven bench for trig_counter_bank (NCH=4, WIDTH=16).
module tb_trig_counter_bank;

  localparam int NCH   = 4;
  localparam int WIDTH = 16;

  logic                 sys_clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       trig_reset, trig_load, trig_up, trig_down;
  logic [WIDTH-1:0]     load_value;
  logic [NCH-1:0]       free_run, sat_mode, flag_clear;
  logic                 snap_req;
  logic [NCH*WIDTH-1:0] count, snap_data;
  logic                 snap_valid;
  logic [NCH-1:0]       ovf_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            name;
    int               ch;
    bit               rst, ld, up, dn, fc, sat, fr;
    logic [WIDTH-1:0] load;
    logic [WIDTH-1:0] exp_cnt;
    bit               exp_flag;
  } vec_t;

  vec_t             vecs[$];
  logic [WIDTH-1:0] exp_cnt[NCH];
  logic [WIDTH-1:0] e;

  trig_counter_bank #(
    .NCH  (NCH),
    .WIDTH(WIDTH)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .trig_reset(trig_reset),
    .trig_load (trig_load),
    .trig_up   (trig_up),
    .trig_down (trig_down),
    .load_value(load_value),
    .free_run  (free_run),
    .sat_mode  (sat_mode),
    .flag_clear(flag_clear),
    .snap_req  (snap_req),
    .count     (count),
    .snap_data (snap_data),
    .snap_valid(snap_valid),
    .ovf_flag  (ovf_flag)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [WIDTH-1:0] cnt_of(int ch);
    return count[ch*WIDTH +: WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] snap_of(int ch);
    return snap_data[ch*WIDTH +: WIDTH];
  endfunction

  task automatic clearPulses();
    trig_reset = '0;
    trig_load  = '0;
    trig_up    = '0;
    trig_down  = '0;
    flag_clear = '0;
    snap_req   = 1'b0;
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    clearPulses();
    sat_mode[v.ch]   = v.sat;
    free_run[v.ch]   = v.fr;
    trig_reset[v.ch] = v.rst;
    trig_load[v.ch]  = v.ld;
    trig_up[v.ch]    = v.up;
    trig_down[v.ch]  = v.dn;
    flag_clear[v.ch] = v.fc;
    load_value       = v.load;
    step();
    clearPulses();
    free_run[v.ch] = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load_value = '0;
    free_run   = '0;
    sat_mode   = '0;
    clearPulses();
    for (int i = 0; i < NCH; i++) exp_cnt[i] = '0;

    // name, ch, rst, ld, up, dn, fc, sat, fr, load, exp_cnt, exp_flag
    vecs.push_back('{"up0_a",       0, 0,0,1,0,0, 0,0, 16'h0000, 16'h0001, 0});
    vecs.push_back('{"up0_b",       0, 0,0,1,0,0, 0,0, 16'h0000, 16'h0002, 0});
    vecs.push_back('{"up0_c",       0, 0,0,1,0,0, 0,0, 16'h0000, 16'h0003, 0});
    vecs.push_back('{"dn0",         0, 0,0,0,1,0, 0,0, 16'h0000, 16'h0002, 0});
    vecs.push_back('{"ld1_ff",      1, 0,1,0,0,0, 0,0, 16'hFFFF, 16'hFFFF, 0});
    vecs.push_back('{"wrap_up1",    1, 0,0,1,0,0, 0,0, 16'h0000, 16'h0000, 1});
    vecs.push_back('{"fclr1",       1, 0,0,0,0,1, 0,0, 16'h0000, 16'h0000, 0});
    vecs.push_back('{"wrap_dn1",    1, 0,0,0,1,0, 0,0, 16'h0000, 16'hFFFF, 1});
    vecs.push_back('{"rst1",        1, 1,0,0,0,0, 0,0, 16'h0000, 16'h0000, 0});
    vecs.push_back('{"ld2_1",       2, 0,1,0,0,0, 1,0, 16'h0001, 16'h0001, 0});
    vecs.push_back('{"sat_dn2_a",   2, 0,0,0,1,0, 1,0, 16'h0000, 16'h0000, 0});
    vecs.push_back('{"sat_dn2_b",   2, 0,0,0,1,0, 1,0, 16'h0000, 16'h0000, 1});
    vecs.push_back('{"sat_dn2_c",   2, 0,0,0,1,0, 1,0, 16'h0000, 16'h0000, 1});
    vecs.push_back('{"rst2",        2, 1,0,0,0,0, 1,0, 16'h0000, 16'h0000, 0});
    vecs.push_back('{"ld2_ff",      2, 0,1,0,0,0, 1,0, 16'hFFFF, 16'hFFFF, 0});
    vecs.push_back('{"sat_up2",     2, 0,0,1,0,0, 1,0, 16'h0000, 16'hFFFF, 1});
    vecs.push_back('{"clr_vs_set2", 2, 0,0,1,0,1, 1,0, 16'h0000, 16'hFFFF, 1});
    vecs.push_back('{"fclr2",       2, 0,0,0,0,1, 1,0, 16'h0000, 16'hFFFF, 0});
    vecs.push_back('{"mode_chg2",   2, 0,0,0,0,0, 0,0, 16'h0000, 16'hFFFF, 0});
    vecs.push_back('{"wrap_up2",    2, 0,0,1,0,0, 0,0, 16'h0000, 16'h0000, 1});
    vecs.push_back('{"ld_keep2",    2, 0,1,0,0,0, 0,0, 16'h1234, 16'h1234, 1});
    vecs.push_back('{"rst_ld_up3",  3, 1,1,1,0,0, 0,0, 16'h0055, 16'h0000, 0});
    vecs.push_back('{"up_dn3",      3, 0,0,1,1,0, 0,0, 16'h0000, 16'h0000, 0});
    vecs.push_back('{"up_dn_fr3",   3, 0,0,1,1,0, 0,1, 16'h0000, 16'h0000, 0});
    vecs.push_back('{"ld3",         3, 0,1,0,0,0, 0,0, 16'h0055, 16'h0055, 0});
    vecs.push_back('{"ld_dn3",      3, 0,1,0,1,0, 0,0, 16'h0010, 16'h0010, 0});

    step();
    step();
    checkOutput("reset_count", count, '0);
    checkOutput("reset_snap", snap_data, '0);
    checkOutput("reset_valid", snap_valid, 1'b0);
    checkOutput("reset_flag", ovf_flag, '0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      exp_cnt[vecs[k].ch] = vecs[k].exp_cnt;
      for (int c = 0; c < NCH; c++)
        checkOutput($sformatf("%s_cnt%0d", vecs[k].name, c), cnt_of(c), exp_cnt[c]);
      checkOutput($sformatf("%s_flag", vecs[k].name), ovf_flag[vecs[k].ch], vecs[k].exp_flag);
    end

    // Free-run on channel 3 with a load landing mid-sequence.
    trig_reset[3] = 1'b1;
    step();
    clearPulses();
    checkOutput("fr_start", cnt_of(3), '0);
    e = '0;
    free_run[3] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin
        trig_load[3] = 1'b1;
        load_value   = 16'h0100;
      end
      step();
      clearPulses();
      e = (c == 5) ? 16'h0100 : e + 16'h0001;
      checkOutput($sformatf("fr_cycle%0d", c), cnt_of(3), e);
    end
    free_run[3] = 1'b0;
    exp_cnt[3] = e;
    checkOutput("fr_final", cnt_of(3), 16'h0104);

    // Snapshot coinciding with an increment captures the pre-update value.
    trig_load[0] = 1'b1;
    load_value   = 16'h0007;
    step();
    clearPulses();
    exp_cnt[0] = 16'h0007;
    snap_req   = 1'b1;
    trig_up[0] = 1'b1;
    step();
    clearPulses();
    for (int c = 0; c < NCH; c++)
      checkOutput($sformatf("snap_ch%0d", c), snap_of(c), exp_cnt[c]);
    checkOutput("snap_cnt0", cnt_of(0), 16'h0008);
    checkOutput("snap_valid_hi", snap_valid, 1'b1);
    step();
    checkOutput("snap_valid_lo", snap_valid, 1'b0);
    checkOutput("snap_hold", snap_of(0), 16'h0007);

    // Back-to-back snapshots each capture and pulse valid.
    for (int c = 0; c < 2; c++) begin
      snap_req   = 1'b1;
      trig_up[0] = 1'b1;
      step();
      checkOutput($sformatf("b2b_snap%0d", c), snap_of(0), 16'h0008 + 16'(c));
      checkOutput($sformatf("b2b_valid%0d", c), snap_valid, 1'b1);
    end
    clearPulses();
    step();
    checkOutput("b2b_cnt0", cnt_of(0), 16'h000A);
    checkOutput("b2b_valid_end", snap_valid, 1'b0);

    // Reset with everything active clears all outputs on the next edge.
    reset      = 1'b1;
    snap_req   = 1'b1;
    trig_up    = '1;
    trig_load  = '1;
    load_value = 16'hABCD;
    free_run   = '1;
    step();
    checkOutput("mid_reset_count", count, '0);
    checkOutput("mid_reset_snap", snap_data, '0);
    checkOutput("mid_reset_valid", snap_valid, 1'b0);
    checkOutput("mid_reset_flag", ovf_flag, '0);
    reset = 1'b0;
    clearPulses();
    free_run = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
